gf_inverter: RTL and testbench

Sequencing stage that computes the GF(2^8) inverse of one redundant-representation operand as a^254 by driving the serial `multiplier` through a fixed square-and-multiply schedule. It sits directly upstream of the multiplier and also consumes its output. It issues operand pairs on the multiplier's `drdy_i/p1/p2`, collects `out` on `drdy_o`, and presents the final representative to the S-box datapath. No reduction is done here: all arithmetic happens in the multiplier modulo its PQ.

---
 rtl/gf_inverter.sv | 139 +++++++++++++
 tb/tb_gf_inverter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_inverter.sv
// gf_inverter: GF(2^8) inverse a^254 via 13 square/multiply ops on an external
// serial multiplier; operands are (8+d)-bit redundant representatives.
// Ports: clk, rst (async, active-low), drdy_i/a (request), drdy_o/out (result),
//   busy, err (watchdog abort), mul_drdy_i/mul_p1/mul_p2 -> multiplier,
//   mul_drdy_o/mul_out <- multiplier.
// Option: INV_TIMEOUT_EN enables the WAIT watchdog (TIMEOUT cycles).
module gf_inverter #(
  parameter int d       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  logic [0:7+d] a,
  output logic         drdy_o,
  output logic [0:7+d] out,
  output logic         busy,
  output logic         err,
  output logic         mul_drdy_i,
  output logic [0:7+d] mul_p1,
  output logic [0:7+d] mul_p2,
  input  logic         mul_drdy_o,
  input  logic [0:7+d] mul_out
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [0:7+d] r_a_q;
  logic [0:7+d] r_acc;
  logic [0:7+d] r_out;
  logic [3:0]   r_op;
  logic         w_last;
  logic         w_abort;

  if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("gf_inverter: TIMEOUT must be 2..1023");
  end

  assign w_last = (r_op == 4'd12);

`ifdef INV_TIMEOUT_EN
  logic [9:0] r_wdog;
  logic       r_err;

  // A result arriving on the limit cycle takes priority over the abort.
  assign w_abort = (r_state == WAIT) && !mul_drdy_o &&
                   (r_wdog == 10'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_abort;
      if (r_state == ISSUE)
        r_wdog <= '0;
      else if (r_state == WAIT)
        r_wdog <= r_wdog + 10'd1;
    end
  end

  assign err = r_err;
`else
  assign w_abort = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (drdy_i) w_next = ISSUE;
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (mul_drdy_o)
          w_next = w_last ? DONE : ISSUE;
        else if (w_abort)
          w_next = IDLE;
      end
      DONE:  w_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != IDLE);
    mul_drdy_i = (r_state == ISSUE);
    drdy_o     = (r_state == DONE);
  end

  // Final product is loaded into out on the way into DONE so it is
  // already valid in the cycle drdy_o is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_q <= '0;
      r_acc <= '0;
      r_out <= '0;
      r_op  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (drdy_i) begin
            r_a_q <= a;
            r_acc <= a;
            r_op  <= '0;
          end
        end
        WAIT: begin
          if (mul_drdy_o) begin
            r_acc <= mul_out;
            if (w_last)
              r_out <= mul_out;
            else
              r_op <= r_op + 4'd1;
          end else if (w_abort) begin
            r_acc <= '0;
            r_op  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Even ops square the accumulator, odd ops multiply it by a.
  assign mul_p1 = r_acc;
  assign mul_p2 = r_op[0] ? r_a_q : r_acc;
  assign out    = r_out;

endmodule

// File: tb/tb_gf_inverter.sv
// tb_gf_inverter: checks gf_inverter against a behavioural GF(2^8) model,
// using a bench-side multiplier model with latency L and redundant outputs.
module tb_gf_inverter;

  localparam int D   = 8;
  localparam int W   = 8 + D;
  localparam int L   = 3;
  localparam int TMO = 64;
  localparam int LAT = 13 * (L + 1) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         drdy_i = 1'b0;
  logic [W-1:0] a = '0;
  logic         drdy_o;
  logic [W-1:0] out;
  logic         busy;
  logic         err;
  logic         mul_drdy_i;
  logic [W-1:0] mul_p1;
  logic [W-1:0] mul_p2;
  logic         mul_drdy_o;
  logic [W-1:0] mul_out;

  logic         stall = 1'b0;
  logic [L-1:0] sreg;

  int checks = 0;
  int failures = 0;
  int errcnt = 0;

  always #5 clk = ~clk;

  gf_inverter #(.d(D), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .drdy_i     (drdy_i),
    .a          (a),
    .drdy_o     (drdy_o),
    .out        (out),
    .busy       (busy),
    .err        (err),
    .mul_drdy_i (mul_drdy_i),
    .mul_p1     (mul_p1),
    .mul_p2     (mul_p2),
    .mul_drdy_o (mul_drdy_o),
    .mul_out    (mul_out)
  );

  function automatic logic [31:0] clmul(input logic [15:0] x,
                                        input logic [15:0] y);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (y[i]) r = r ^ (32'(x) << i);
    return r;
  endfunction

  function automatic logic [7:0] pmod(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    for (int i = 31; i >= 8; i--)
      if (t[i]) t = t ^ (32'h11B << (i - 8));
    return t[7:0];
  endfunction

  // Inverse by exhaustive search: the y with x*y == 1 mod 0x11B.
  function automatic logic [7:0] ref_inv(input logic [15:0] x);
    logic [7:0] x8;
    x8 = pmod(32'(x));
    if (x8 == 8'd0) return 8'd0;
    for (int y = 1; y < 256; y++)
      if (pmod(clmul(16'(x8), 16'(y))) == 8'd1) return 8'(y);
    return 8'd0;
  endfunction

  // Multiplier model: latency L, result = product plus a random
  // multiple of 0x11B so the inverter sees redundant representatives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      mul_out <= '0;
    end else begin
      sreg <= {sreg[L-2:0], mul_drdy_i};
      if (mul_drdy_i)
        mul_out <= 16'(pmod(clmul(mul_p1, mul_p2))) ^
                   16'(clmul(16'h011B, 16'($urandom_range(0, 255))));
    end
  end

  assign mul_drdy_o = sreg[L-1] & ~stall;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_inv(input logic [15:0] av, input logic [7:0] ex,
                         input string nm, input bit inject);
    int n, pulses, unstable, notbusy;
    bit done, op0, op1;
    logic [W-1:0] hp1, hp2, hold;
    n = 1; pulses = 0; unstable = 0; notbusy = 0;
    done = 0; op0 = 0; op1 = 0; hp1 = '0; hp2 = '0;
    @(negedge clk);
    a = av; drdy_i = 1'b1;
    @(negedge clk);
    drdy_i = 1'b0; a = 16'($urandom);
    while (n <= LAT + 20) begin
      if (drdy_o) begin
        done = 1;
        break;
      end
      if (!busy) notbusy++;
      if (err) errcnt++;
      if (mul_drdy_i) begin
        pulses++; hp1 = mul_p1; hp2 = mul_p2;
      end else if (mul_p1 != hp1 || mul_p2 != hp2) begin
        unstable++;
      end
      if (n == 1)
        op0 = (mul_p1 == av) && (mul_p2 == av) && mul_drdy_i;
      if (n == 1 + (L + 1))
        op1 = (mul_p2 == av) && mul_drdy_i;
      if (inject && n == 1 + 5 * (L + 1)) begin
        drdy_i = 1'b1; a = 16'h0003;
      end else begin
        drdy_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    drdy_i = 1'b0;
    chk(done && n == LAT, {nm, " latency"}, n, LAT);
    chk(done && pmod(32'(out)) == ex, {nm, " result"},
        pmod(32'(out)), ex);
    chk(pulses == 13, {nm, " mul pulses"}, pulses, 13);
    chk(op0, {nm, " op0 operands"}, {hp1, hp2}, av);
    chk(op1, {nm, " op1 operand"}, mul_p2, av);
    chk(unstable == 0, {nm, " operand stability"}, unstable, 0);
    chk(notbusy == 0, {nm, " busy held"}, notbusy, 0);
    hold = out;
    @(negedge clk);
    chk(!drdy_o && !busy && out == hold, {nm, " drdy_o pulse"},
        {drdy_o, busy, out}, {2'b00, hold});
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  ex;
    string       nm;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    logic [15:0] ra;
    tbl[0] = '{16'h0002, 8'h8D, "inv_02"};
    tbl[1] = '{16'h0053, 8'hCA, "inv_53"};
    tbl[2] = '{16'h0001, 8'h01, "inv_01"};
    tbl[3] = '{16'h0000, 8'h00, "inv_00"};
    tbl[4] = '{16'h011B, 8'h00, "inv_11b"};

    repeat (2) @(negedge clk);
    chk({drdy_o, busy, err, mul_drdy_i} == 4'b0 && out == '0 &&
        mul_p1 == '0 && mul_p2 == '0, "reset state",
        {drdy_o, busy, err, mul_drdy_i, out}, 0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++)
      run_inv(tbl[i].a, tbl[i].ex, tbl[i].nm, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      run_inv(ra, ref_inv(ra), $sformatf("rand%0d", i), 1'b0);
    end

    run_inv(16'h0002, 8'h8D, "ignore_drdy", 1'b1);

    // Asynchronous reset while waiting on op 7.
    @(negedge clk);
    a = 16'h0002; drdy_i = 1'b1;
    @(negedge clk);
    drdy_i = 1'b0;
    n = 1;
    while (n < 1 + 7 * (L + 1) + 1) begin
      @(negedge clk);
      n++;
    end
    chk(busy && !mul_drdy_i, "op7 in wait", {busy, mul_drdy_i}, 2'b10);
    #1 rst = 1'b0;
    #1;
    chk({drdy_o, busy, err, mul_drdy_i} == 4'b0 && out == '0 &&
        mul_p1 == '0 && mul_p2 == '0, "async reset",
        {drdy_o, busy, err, mul_drdy_i, out}, 0);
    @(negedge clk);
    rst = 1'b1;
    run_inv(16'h0002, 8'h8D, "post_reset", 1'b0);

`ifdef INV_TIMEOUT_EN
    begin
      int errn, errp;
      bit busy_at, sawdone;
      errn = 0; errp = 0; busy_at = 1; sawdone = 0;
      stall = 1'b1;
      @(negedge clk);
      a = 16'h0002; drdy_i = 1'b1;
      @(negedge clk);
      drdy_i = 1'b0;
      n = 1;
      while (n < 200) begin
        if (err) begin
          errp++;
          if (errn == 0) begin
            errn = n; busy_at = busy;
          end
        end
        if (drdy_o) sawdone = 1;
        @(negedge clk);
        n++;
      end
      stall = 1'b0;
      chk(errn == TMO + 2, "timeout err cycle", errn, TMO + 2);
      chk(!busy_at, "timeout idle", busy_at, 0);
      chk(errp == 1 && !sawdone, "timeout single err",
          {errp, 31'(sawdone)}, 1);
      run_inv(16'h0053, 8'hCA, "after_timeout", 1'b0);
    end
`endif

    chk(errcnt == 0, "no err in normal runs", errcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
